mem_access_multi: RTL and testbench

Memory access unit directly downstream of the multicycle control FSM. Consumes its MemRead/MemWrite/IouD strobes plus datapath PC, ALUOut and rs2 value, and drives a synchronous single-port RAM. Performs one RAM access per request edge and generates byte enables for SB/SH/SW. Loads and sign/zero-extends LB/LH/LW/LBU/LHU data into the memory data register (MDR) and forwards raw fetch data to the instruction register.

---
 rtl/mem_access_multi_pkg.sv | 49 ++++
 rtl/mem_access_multi_load_extend.sv | 36 +++
 rtl/mem_access_multi.sv | 144 ++++++++++++++
 tb/tb_mem_access_multi.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_multi_pkg.sv
// Shared types for the multicycle memory access unit: FSM states, funct3 codes,
// and store-lane / alignment helpers.
package mem_access_multi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RD_WAIT = 2'd1,
    ST_RD_CAP  = 2'd2,
    ST_WR      = 2'd3
  } state_t;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  function automatic logic [3:0] store_byte_en(input logic [2:0] f3, input logic [1:0] off);
    case (f3)
      F3_SB:   return 4'b0001 << off;
      F3_SH:   return off[1] ? 4'b1100 : 4'b0011;
      F3_SW:   return 4'b1111;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_lane_data(input logic [2:0] f3, input logic [31:0] rs2);
    case (f3)
      F3_SB:   return {4{rs2[7:0]}};
      F3_SH:   return {2{rs2[15:0]}};
      F3_SW:   return rs2;
      default: return rs2;
    endcase
  endfunction

  // Unsigned byte/half codes only exist for loads; for stores they are word accesses.
  function automatic logic is_misaligned(input logic is_wr, input logic [2:0] f3,
                                         input logic [1:0] off);
    logic w_byte;
    logic w_half;
    w_byte = (f3 == F3_LB) || (!is_wr && f3 == F3_LBU);
    w_half = (f3 == F3_LH) || (!is_wr && f3 == F3_LHU);
    return w_half ? off[0] : (!w_byte && off != 2'b00);
  endfunction

endpackage

// File: rtl/mem_access_multi_load_extend.sv
// Combinational load lane select and sign/zero extension (LB/LH/LW/LBU/LHU).
// Zero latency; half selects use offset bit 1 only, so odd half addresses align down.
module mem_load_extend
  import mem_access_multi_pkg::*;
(
  input  logic [31:0] i_data,
  input  logic [1:0]  i_off,
  input  logic [2:0]  i_funct3,
  output logic [31:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    case (i_off)
      2'd0:    w_byte = i_data[7:0];
      2'd1:    w_byte = i_data[15:8];
      2'd2:    w_byte = i_data[23:16];
      default: w_byte = i_data[31:24];
    endcase
    w_half = i_off[1] ? i_data[31:16] : i_data[15:0];
  end

  always_comb begin
    case (i_funct3)
      F3_LB:   o_data = {{24{w_byte[7]}}, w_byte};
      F3_LH:   o_data = {{16{w_half[15]}}, w_half};
      F3_LW:   o_data = i_data;
      F3_LBU:  o_data = {24'd0, w_byte};
      F3_LHU:  o_data = {16'd0, w_half};
      default: o_data = i_data;
    endcase
  end

endmodule

// File: rtl/mem_access_multi.sv
// Memory access unit behind the multicycle control FSM: one RAM access per strobe edge,
// store lanes, load extend into MDR, raw fetch to IR. Optional trap: MEM_MISALIGN_TRAP_EN.
module mem_access_multi
  import mem_access_multi_pkg::*;
#(
  parameter int RD_LAT = 1,
  parameter int ADDR_W = 32
) (
  input  logic              iCLK,
  input  logic              iRST,
  input  logic              iMemRead,
  input  logic              iMemWrite,
  input  logic              iIouD,
  input  logic [ADDR_W-1:0] iPC,
  input  logic [31:0]       iALUOut,
  input  logic [31:0]       iStoreData,
  input  logic [2:0]        iFunct3,
  output logic [ADDR_W-1:0] oMemAddr,
  output logic [31:0]       oMemWData,
  output logic [3:0]        oMemByteEn,
  output logic              oMemWE,
  output logic              oMemRE,
  input  logic [31:0]       iMemRData,
  output logic [31:0]       oInstr,
  output logic [31:0]       oMDR,
  output logic              oBusy,
  output logic              oMisalign
);

  localparam logic [1:0] CNT_INIT = 2'(RD_LAT - 1);

  state_t            r_state;
  state_t            w_next;
  logic              r_armed;
  logic [1:0]        r_cnt;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic [3:0]        r_be;
  logic [2:0]        r_f3;
  logic [1:0]        r_off;
  logic              r_iou;
  logic              r_sup;
  logic              r_mis;
  logic [31:0]       r_instr;
  logic [31:0]       r_mdr;

  logic [ADDR_W-1:0] w_addr;
  logic              w_req;
  logic              w_accept;
  logic              w_sup;
  logic [31:0]       w_ext;

  assign w_addr   = iIouD ? iALUOut[ADDR_W-1:0] : iPC;
  assign w_req    = iMemRead || iMemWrite;
  assign w_accept = (r_state == ST_IDLE) && r_armed && w_req;

`ifdef MEM_MISALIGN_TRAP_EN
  assign w_sup = iIouD && is_misaligned(iMemWrite, iFunct3, w_addr[1:0]);
`else
  assign w_sup = 1'b0;
`endif

  mem_load_extend u_load_extend (
    .i_data   (iMemRData),
    .i_off    (r_off),
    .i_funct3 (r_f3),
    .o_data   (w_ext)
  );

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  // Write wins when both strobes are raised together.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) w_next = iMemWrite ? ST_WR : ST_RD_WAIT;
      end
      ST_RD_WAIT: begin
        if (r_cnt == 2'd0) w_next = ST_RD_CAP;
      end
      ST_RD_CAP: w_next = ST_IDLE;
      ST_WR:     w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  // The counter sits at its load value only in the first RD_WAIT cycle, so RE pulses once.
  always_comb begin
    oMemWE     = (r_state == ST_WR) && !r_sup;
    oMemRE     = (r_state == ST_RD_WAIT) && (r_cnt == CNT_INIT) && !r_sup;
    oMemByteEn = ((r_state == ST_WR) && !r_sup) ? r_be : 4'b0000;
    oBusy      = (r_state == ST_RD_WAIT) || (r_state == ST_RD_CAP);
    oInstr     = ((r_state == ST_RD_CAP) && !r_iou) ? iMemRData : r_instr;
  end

  assign oMemAddr  = r_addr;
  assign oMemWData = r_wdata;
  assign oMDR      = r_mdr;
  assign oMisalign = r_mis;

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      r_armed <= 1'b1;
      r_cnt   <= 2'd0;
      r_addr  <= '0;
      r_wdata <= 32'd0;
      r_be    <= 4'd0;
      r_f3    <= 3'd0;
      r_off   <= 2'd0;
      r_iou   <= 1'b0;
      r_sup   <= 1'b0;
      r_mis   <= 1'b0;
      r_instr <= 32'd0;
      r_mdr   <= 32'd0;
    end else begin
      if (w_accept)    r_armed <= 1'b0;
      else if (!w_req) r_armed <= 1'b1;

      if (w_accept) begin
        r_addr  <= {w_addr[ADDR_W-1:2], 2'b00};
        r_be    <= store_byte_en(iFunct3, w_addr[1:0]);
        r_wdata <= store_lane_data(iFunct3, iStoreData);
        r_f3    <= iFunct3;
        r_off   <= w_addr[1:0];
        r_iou   <= iIouD;
        r_sup   <= w_sup;
        r_cnt   <= CNT_INIT;
        if (w_sup) r_mis <= 1'b1;
      end else if ((r_state == ST_RD_WAIT) && (r_cnt != 2'd0)) begin
        r_cnt <= r_cnt - 2'd1;
      end

      if (r_state == ST_RD_CAP) begin
        if (!r_iou)      r_instr <= iMemRData;
        else if (!r_sup) r_mdr   <= w_ext;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_multi.sv
// Bench for mem_access_multi: RAM model with RD_LAT pipeline, transaction-level reference
// model of expected strobes/results per cycle, directed cases followed by random accesses.
module tb_mem_access_multi;

  localparam int LAT = 3;
  localparam int BIG = 32'h7fffffff;
`ifdef MEM_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        iCLK = 1'b0;
  logic        iRST = 1'b1;
  logic        iMemRead = 1'b0;
  logic        iMemWrite = 1'b0;
  logic        iIouD = 1'b0;
  logic [31:0] iPC = '0;
  logic [31:0] iALUOut = '0;
  logic [31:0] iStoreData = '0;
  logic [2:0]  iFunct3 = '0;
  logic [31:0] iMemRData;
  logic [31:0] oMemAddr, oMemWData, oInstr, oMDR;
  logic [3:0]  oMemByteEn;
  logic        oMemWE, oMemRE, oBusy, oMisalign;

  always #5 iCLK = ~iCLK;

  mem_access_multi #(.RD_LAT(LAT), .ADDR_W(32)) dut (
    .iCLK(iCLK), .iRST(iRST), .iMemRead(iMemRead), .iMemWrite(iMemWrite), .iIouD(iIouD),
    .iPC(iPC), .iALUOut(iALUOut), .iStoreData(iStoreData), .iFunct3(iFunct3),
    .oMemAddr(oMemAddr), .oMemWData(oMemWData), .oMemByteEn(oMemByteEn), .oMemWE(oMemWE),
    .oMemRE(oMemRE), .iMemRData(iMemRData), .oInstr(oInstr), .oMDR(oMDR), .oBusy(oBusy),
    .oMisalign(oMisalign)
  );

  // RAM model: byte-enabled writes, reads return after LAT cycles, junk otherwise.
  logic [31:0] ram [0:63];
  logic [31:0] ref_mem [0:63];
  logic [31:0] rd_pipe [0:LAT-1];
  logic        poke_en = 1'b0;
  logic [5:0]  poke_idx = '0;
  logic [31:0] poke_dat = '0;
  int          cyc = 0;

  always @(posedge iCLK) begin
    cyc <= cyc + 1;
    if (poke_en) ram[poke_idx] <= poke_dat;
    if (oMemWE)
      for (int b = 0; b < 4; b++)
        if (oMemByteEn[b]) ram[oMemAddr[7:2]][8*b +: 8] <= oMemWData[8*b +: 8];
    rd_pipe[0] <= oMemRE ? ram[oMemAddr[7:2]] : {16'hDEAD, cyc[15:0]};
    for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign iMemRData = rd_pipe[LAT-1];

  int nvec = 0;
  int nerr = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  // Expected behaviour expressed as event cycles and before/after values.
  int          we_at = -1, re_at = -1, busy_lo = BIG, busy_hi = -1;
  int          instr_sw = 0, mdr_sw = 0, mis_from = BIG;
  logic [31:0] exp_addr = '0, exp_wd = '0;
  logic [3:0]  exp_be = '0;
  logic [31:0] instr_old = '0, instr_new = '0, mdr_old = '0, mdr_new = '0;
  bit          mon_en = 1'b0;

  always @(negedge iCLK) begin
    if (mon_en) begin
      logic we_e, re_e;
      we_e = (cyc == we_at);
      re_e = (cyc == re_at);
      chk("oMemWE", 32'(oMemWE), 32'(we_e));
      chk("oMemRE", 32'(oMemRE), 32'(re_e));
      chk("oMemByteEn", 32'(oMemByteEn), we_e ? 32'(exp_be) : 32'h0);
      if (we_e) begin
        chk("wr_addr", oMemAddr, exp_addr);
        chk("wr_data", oMemWData, exp_wd);
      end
      if (re_e) chk("rd_addr", oMemAddr, exp_addr);
      chk("oBusy", 32'(oBusy), 32'(cyc >= busy_lo && cyc <= busy_hi));
      chk("oInstr", oInstr, (cyc >= instr_sw) ? instr_new : instr_old);
      chk("oMDR", oMDR, (cyc >= mdr_sw) ? mdr_new : mdr_old);
      chk("oMisalign", 32'(oMisalign), 32'(cyc >= mis_from));
    end
  end

  function automatic logic [31:0] ld_model(input logic [31:0] w, input int off,
                                           input logic [2:0] f3);
    logic [31:0] b, h;
    b = (w >> (8 * off)) & 32'hFF;
    h = (w >> (16 * (off / 2))) & 32'hFFFF;
    case (f3)
      3'd0:    return (b >= 128) ? (b | 32'hFFFFFF00) : b;
      3'd1:    return (h >= 32768) ? (h | 32'hFFFF0000) : h;
      3'd4:    return b;
      3'd5:    return h;
      default: return w;
    endcase
  endfunction

  task automatic poke(input int idx, input logic [31:0] v);
    ref_mem[idx] = v;
    poke_en = 1'b1; poke_idx = 6'(idx); poke_dat = v;
    @(posedge iCLK); #1;
    poke_en = 1'b0;
  endtask

  task automatic settle(input int n);
    repeat (n) @(posedge iCLK);
    #1;
  endtask

  // Called at posedge+1; raises the strobes for 'hold' cycles and records expectations.
  task automatic issue(input bit wr, input bit rd, input bit iou, input logic [31:0] pc,
                       input logic [31:0] alu, input logic [2:0] f3, input logic [31:0] rs2,
                       input int hold);
    logic [31:0] a, wd;
    logic [3:0]  be;
    int c, off, idx, wsz;
    bit mis, isld;
    a = iou ? alu : pc;
    off = int'(a[1:0]);
    idx = int'(a[7:2]);
    isld = !wr;
    wsz = (f3 == 3'd0 || (isld && f3 == 3'd4)) ? 1 : (f3 == 3'd1 || (isld && f3 == 3'd5)) ? 2 : 4;
    mis = TRAP && iou && (off % wsz != 0);
    c = cyc;
    iMemWrite = wr; iMemRead = rd; iIouD = iou; iPC = pc; iALUOut = alu;
    iFunct3 = f3; iStoreData = rs2;
    instr_old = instr_new; mdr_old = mdr_new;
    if (mis && c + 1 < mis_from) mis_from = c + 1;
    if (wr) begin
      if (!mis) begin
        if (f3 == 3'd0) begin
          be = 4'(1 << off); wd = (rs2 & 32'hFF) * 32'h01010101;
        end else if (f3 == 3'd1) begin
          be = (off >= 2) ? 4'hC : 4'h3; wd = (rs2 & 32'hFFFF) * 32'h00010001;
        end else begin
          be = 4'hF; wd = rs2;
        end
        we_at = c + 1; exp_addr = a & 32'hFFFFFFFC; exp_be = be; exp_wd = wd;
        for (int b = 0; b < 4; b++)
          if (be[b]) ref_mem[idx][8*b +: 8] = wd[8*b +: 8];
      end
    end else if (rd) begin
      busy_lo = c + 1; busy_hi = c + 1 + LAT;
      if (!mis) begin
        re_at = c + 1; exp_addr = a & 32'hFFFFFFFC;
      end
      if (!iou) begin
        instr_new = ref_mem[idx]; instr_sw = c + 1 + LAT;
      end else if (!mis) begin
        mdr_new = ld_model(ref_mem[idx], off, f3); mdr_sw = c + 2 + LAT;
      end
    end
    // Disturb address/width inputs while the strobe is held; they must already be latched.
    for (int h = 1; h < hold; h++) begin
      @(posedge iCLK); #1;
      iPC = $urandom; iALUOut = $urandom; iFunct3 = 3'($urandom); iIouD = 1'($urandom);
      iStoreData = $urandom;
    end
    @(posedge iCLK); #1;
    iMemWrite = 1'b0; iMemRead = 1'b0;
  endtask

  task automatic access(input bit wr, input bit rd, input bit iou, input logic [31:0] pc,
                        input logic [31:0] alu, input logic [2:0] f3, input logic [31:0] rs2);
    issue(wr, rd, iou, pc, alu, f3, rs2, 2);
    settle(LAT + 1);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_we"}, 32'(oMemWE), 32'h0);
    chk({tag, "_re"}, 32'(oMemRE), 32'h0);
    chk({tag, "_be"}, 32'(oMemByteEn), 32'h0);
    chk({tag, "_addr"}, oMemAddr, 32'h0);
    chk({tag, "_wdata"}, oMemWData, 32'h0);
    chk({tag, "_instr"}, oInstr, 32'h0);
    chk({tag, "_mdr"}, oMDR, 32'h0);
    chk({tag, "_busy"}, 32'(oBusy), 32'h0);
    chk({tag, "_misalign"}, 32'(oMisalign), 32'h0);
  endtask

  initial begin
    repeat (50000) @(posedge iCLK);
    nerr++;
    $display("FAIL watchdog: run exceeded 50000 cycles");
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    int bad;
    iRST = 1'b0;
    #1;
    for (int i = 0; i < 64; i++) poke(i, $urandom);
    chk_all_zero("reset");
    iRST = 1'b1;
    mon_en = 1'b1;
    settle(2);

    // Fetch
    poke(4, 32'h00500093);
    access(0, 1, 0, 32'h10, 32'hFFFFFFF0, 3'd2, 32'h0);
    chk("fetch_instr", oInstr, 32'h00500093);
    chk("fetch_mdr_kept", oMDR, 32'h0);

    // Load extension
    poke(8, 32'h80FF7F01);
    access(0, 1, 1, 32'h0, 32'h23, 3'd0, 32'h0);
    chk("lb_sign", oMDR, 32'hFFFFFF80);
    access(0, 1, 1, 32'h0, 32'h23, 3'd4, 32'h0);
    chk("lbu_zero", oMDR, 32'h00000080);
    access(0, 1, 1, 32'h0, 32'h22, 3'd1, 32'h0);
    chk("lh_sign", oMDR, 32'hFFFF80FF);

    // SB lane and readback
    poke(16, 32'h11223344);
    access(1, 0, 1, 32'h0, 32'h41, 3'd0, 32'h000000AB);
    access(0, 1, 1, 32'h0, 32'h40, 3'd2, 32'h0);
    chk("sb_readback", oMDR, 32'h1122AB44);

    // Long-held write must not retrigger; then a read
    issue(1, 0, 1, 32'h0, 32'h44, 3'd2, 32'h5A5A0001, 4);
    settle(1);
    access(0, 1, 1, 32'h0, 32'h44, 3'd2, 32'h0);
    chk("held_wr_then_rd", oMDR, 32'h5A5A0001);

    // Read and write together: write only
    access(1, 1, 1, 32'h0, 32'h48, 3'd2, 32'h0BADCAFE);
    access(0, 1, 1, 32'h0, 32'h48, 3'd2, 32'h0);
    chk("rw_write_wins", oMDR, 32'h0BADCAFE);

    // Reset while the read is waiting on RAM latency
    issue(0, 1, 0, 32'h10, 32'h0, 3'd2, 32'h0, 2);
    #1;
    iRST = 1'b0;
    we_at = -1; re_at = -1; busy_lo = BIG; busy_hi = -1; mis_from = BIG;
    instr_old = '0; instr_new = '0; instr_sw = 0; mdr_old = '0; mdr_new = '0; mdr_sw = 0;
    #1;
    chk_all_zero("midread_reset");
    @(posedge iCLK); #1;
    iRST = 1'b1;
    settle(LAT + 3);
    chk("no_capture_after_reset", oInstr, 32'h0);
    access(0, 1, 0, 32'h10, 32'h0, 3'd2, 32'h0);
    chk("fetch_after_reset", oInstr, 32'h00500093);

    // Misaligned SW to 0x42
    access(1, 0, 1, 32'h0, 32'h42, 3'd2, 32'hCAFEF00D);
    access(0, 1, 1, 32'h0, 32'h40, 3'd2, 32'h0);
`ifdef MEM_MISALIGN_TRAP_EN
    chk("sw_misalign_flag", 32'(oMisalign), 32'h1);
    chk("sw_misalign_suppressed", oMDR, 32'h1122AB44);
`else
    chk("sw_misalign_flag", 32'(oMisalign), 32'h0);
    chk("sw_aligned_down", oMDR, 32'hCAFEF00D);
`endif

    // Random traffic
    for (int n = 0; n < 250; n++) begin
      int kind;
      bit both;
      logic [31:0] addr;
      kind = int'($urandom_range(0, 2));
      addr = $urandom & 32'hFF;
      both = ($urandom_range(0, 7) == 0);
      case (kind)
        0: issue(0, 1, 0, addr, $urandom, 3'($urandom), $urandom, 2);
        1: issue(both, 1, 1, $urandom, addr, 3'($urandom), $urandom, 2);
        default: issue(1, both, 1, $urandom, addr, 3'($urandom), $urandom,
                       int'($urandom_range(2, 3)));
      endcase
      settle(LAT + 1 + int'($urandom_range(0, 1)));
    end

    bad = 0;
    for (int i = 0; i < 64; i++) if (ram[i] !== ref_mem[i]) bad++;
    chk("ram_image_words_off", 32'(bad), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
